// File: rtl/keypad_entry_if.sv
// Keypad pins plus calculator-entry outputs, bundled for the keypad_entry block.
// Latency: none (wires only).
// Backpressure: none; every output is a level or a one-cycle pulse.
interface keypad_entry_if;
    logic [3:0]  col;        // keypad columns, active-low, pulled up on the board
    logic [3:0]  row;        // one-cold row drive
    logic [20:0] adata;      // first operand: sign + five BCD digits
    logic [20:0] bdata;      // current entry / second operand
    logic [1:0]  op;         // 0 +, 1 -, 2 *
    logic        calc_go;    // one-cycle compute request
    logic        key_valid;  // one-cycle pulse per debounced press
    logic [3:0]  key_code;   // last accepted key

    // The entry block drives everything except the columns.
    modport master (
        input  col,
        output row, adata, bdata, op, calc_go, key_valid, key_code
    );

    // The keypad / consumer side.
    modport slave (
        output col,
        input  row, adata, bdata, op, calc_go, key_valid, key_code
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce, feeding a two-operand BCD entry FSM.
// Latency: key_valid DEB_SCANS scan ticks after a stable press; fields update 1 clk later.
// Backpressure: none; keys are dropped while a previous press awaits release.
module keypad_entry #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_entry_if.master bus
);

    localparam int          DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          CNT_W = $clog2(DEB_SCANS + 1);
    localparam logic [20:0] EMPTY = 21'h0DDDD0;

    typedef enum logic [1:0] {K_SCAN, K_DEB, K_REL} kstate_t;
    typedef enum logic [1:0] {S_A, S_B, S_DONE}     state_t;

    // ------------------------------------------------------------------
    // Column synchronizer and scan tick
    // ------------------------------------------------------------------
    logic [3:0]       r_col_s1;
    logic [3:0]       r_col_s2;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    // Two-flop synchronizer; idle value is all-high (pull-ups).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
        end else begin
            r_col_s1 <= bus.col;
            r_col_s2 <= r_col_s1;
        end
    end

    // Free-running divider; the tick is the cycle the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

    // ------------------------------------------------------------------
    // Row scan and debounce
    // ------------------------------------------------------------------
    kstate_t          r_kst;
    logic [1:0]       r_idx;
    logic [3:0]       r_row;
    logic [3:0]       r_pat;
    logic [CNT_W-1:0] r_cnt;
    logic             r_key_valid;
    logic [3:0]       r_key_code;

    logic             w_idle;
    logic             w_cnt_done;
    logic [1:0]       w_idx_nx;
    logic [1:0]       w_col_idx;
    logic [3:0]       w_low;

    assign w_idle     = (r_col_s2 == 4'hF);
    assign w_cnt_done = (r_cnt == CNT_W'(DEB_SCANS - 1));
    assign w_idx_nx   = r_idx + 2'd1;
    assign w_low      = ~r_col_s2;

    // With several columns low the lowest-numbered one wins.
    always_comb begin
        w_col_idx = 2'd3;
        if (w_low[2]) w_col_idx = 2'd2;
        if (w_low[1]) w_col_idx = 2'd1;
        if (w_low[0]) w_col_idx = 2'd0;
    end

    // Scanner FSM: walk rows while idle, freeze the row and count stable
    // ticks while a column is low, then demand a stable release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kst       <= K_SCAN;
            r_idx       <= 2'd0;
            r_row       <= 4'b1110;
            r_pat       <= 4'hF;
            r_cnt       <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_kst)
                    K_SCAN: begin
                        if (w_idle) begin
                            r_idx <= w_idx_nx;
                            r_row <= ~(4'b0001 << w_idx_nx);
                        end else if (DEB_SCANS <= 1) begin
                            r_key_valid <= 1'b1;
                            r_key_code  <= {r_idx, w_col_idx};
                            r_cnt       <= '0;
                            r_kst       <= K_REL;
                        end else begin
                            r_pat <= r_col_s2;
                            r_cnt <= CNT_W'(1);
                            r_kst <= K_DEB;
                        end
                    end
                    K_DEB: begin
                        if (w_idle) begin
                            // Glitch ended before debounce: drop it and keep scanning.
                            r_cnt <= '0;
                            r_kst <= K_SCAN;
                            r_idx <= w_idx_nx;
                            r_row <= ~(4'b0001 << w_idx_nx);
                        end else if (r_col_s2 != r_pat) begin
                            r_pat <= r_col_s2;
                            r_cnt <= CNT_W'(1);
                        end else if (w_cnt_done) begin
                            r_key_valid <= 1'b1;
                            r_key_code  <= {r_idx, w_col_idx};
                            r_cnt       <= '0;
                            r_kst       <= K_REL;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    K_REL: begin
                        if (!w_idle) begin
                            r_cnt <= '0;
                        end else if (w_cnt_done) begin
                            r_cnt <= '0;
                            r_kst <= K_SCAN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_cnt <= '0;
                        r_kst <= K_SCAN;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand entry FSM
    // ------------------------------------------------------------------
    state_t      r_st;
    logic [20:0] r_adata;
    logic [20:0] r_bdata;
    logic [1:0]  r_op;
    logic [2:0]  r_n;
    logic        r_calc_go;

    logic        w_is_digit;
    logic        w_is_oper;
    logic        w_is_eq;
    logic        w_is_sign;
    logic        w_is_clr;
    logic        w_digit_zero;
    logic [1:0]  w_op_code;
    logic [20:0] w_b_digit;

    assign w_is_digit   = (r_key_code <= 4'd9);
    assign w_is_oper    = (r_key_code >= 4'd10) && (r_key_code <= 4'd12);
    assign w_is_eq      = (r_key_code == 4'd13);
    assign w_is_sign    = (r_key_code == 4'd14);
    assign w_is_clr     = (r_key_code == 4'd15);
    assign w_digit_zero = (r_key_code == 4'd0);
    // Codes 10/11/12 have low bits 10/11/00; subtracting 2 mod 4 yields 0/1/2.
    assign w_op_code    = r_key_code[1:0] - 2'd2;
    // First digit replaces the empty-field LS zero; later digits shift left.
    assign w_b_digit    = (r_n == 3'd0) ? {r_bdata[20], 16'hDDDD, r_key_code}
                                        : {r_bdata[20], r_bdata[15:0], r_key_code};

    // Entry FSM acts on the key the cycle after key_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st      <= S_A;
            r_adata   <= EMPTY;
            r_bdata   <= EMPTY;
            r_op      <= 2'd0;
            r_n       <= 3'd0;
            r_calc_go <= 1'b0;
        end else begin
            r_calc_go <= 1'b0;
            if (r_key_valid) begin
                if (w_is_clr) begin
                    r_adata <= EMPTY;
                    r_bdata <= EMPTY;
                    r_op    <= 2'd0;
                    r_n     <= 3'd0;
                    r_st    <= S_A;
                end else begin
                    case (r_st)
                        S_A, S_B: begin
                            if (w_is_digit) begin
                                // Leading zeros are absorbed; a sixth digit is dropped.
                                if (!(r_n == 3'd0 && w_digit_zero) && r_n < 3'd5) begin
                                    r_bdata <= w_b_digit;
                                    r_n     <= r_n + 3'd1;
                                end
                            end else if (w_is_sign) begin
                                if (r_n != 3'd0) begin
                                    r_bdata[20] <= ~r_bdata[20];
                                end
                            end else if (w_is_oper) begin
                                r_op <= w_op_code;
                                if (r_st == S_A) begin
                                    r_adata <= r_bdata;
                                    r_bdata <= EMPTY;
                                    r_n     <= 3'd0;
                                    r_st    <= S_B;
                                end
                            end else if (w_is_eq && r_st == S_B) begin
                                r_calc_go <= 1'b1;
                                r_st      <= S_DONE;
                            end
                        end
                        S_DONE: begin
                            // A digit starts a fresh calculation.
                            if (w_is_digit) begin
                                r_adata <= EMPTY;
                                r_op    <= 2'd0;
                                r_st    <= S_A;
                                if (w_digit_zero) begin
                                    r_bdata <= EMPTY;
                                    r_n     <= 3'd0;
                                end else begin
                                    r_bdata <= {1'b0, 16'hDDDD, r_key_code};
                                    r_n     <= 3'd1;
                                end
                            end
                        end
                        default: r_st <= S_A;
                    endcase
                end
            end
        end
    end

    assign bus.row       = r_row;
    assign bus.adata     = r_adata;
    assign bus.bdata     = r_bdata;
    assign bus.op        = r_op;
    assign bus.calc_go   = r_calc_go;
    assign bus.key_valid = r_key_valid;
    assign bus.key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: keypad model drives columns from the row drive,
// stimulus pushes expected key/field results, a monitor pops on each key_valid.
// Runs with SCAN_DIV=4, DEB_SCANS=2.
module tb_keypad_entry;

    localparam logic [20:0] E = 21'h0DDDD0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_if bus();

    keypad_entry #(.SCAN_DIV(4), .DEB_SCANS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Keypad model: the pressed switch pulls its columns low only while its row is driven.
    logic       pressed = 1'b0;
    logic [1:0] prow    = 2'd0;
    logic [3:0] pmask   = 4'd0;
    logic [3:0] w_sel;
    assign w_sel   = ~(4'b0001 << prow);
    assign bus.col = (pressed && bus.row == w_sel) ? ~pmask : 4'hF;

    typedef struct packed {
        logic [3:0]  code;
        logic [20:0] a;
        logic [20:0] b;
        logic [1:0]  op;
        logic        go;
    } exp_t;

    exp_t q[$];
    int n_tests  = 0;
    int n_fail   = 0;
    int n_kv     = 0;
    int n_kv_exp = 0;
    int n_go     = 0;
    int n_go_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every key_valid consumes one expectation; fields are checked a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.key_valid === 1'b1) begin
                n_kv++;
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_key: got key_code %h with no key expected", bus.key_code);
                end else begin
                    e = q.pop_front();
                    chk("key_code", 32'(bus.key_code), 32'(e.code));
                    @(negedge clk);
                    chk("key_valid_width", 32'(bus.key_valid), 32'd0);
                    chk("adata",   32'(bus.adata),   32'(e.a));
                    chk("bdata",   32'(bus.bdata),   32'(e.b));
                    chk("op",      32'(bus.op),      32'(e.op));
                    chk("calc_go", 32'(bus.calc_go), 32'(e.go));
                end
            end
        end
    end

    always @(negedge clk) if (rst_n && bus.calc_go === 1'b1) n_go++;

    // Hold long enough for a full row sweep plus debounce, then a clean release.
    task automatic key_raw(input logic [1:0] r, input logic [3:0] m, input logic [3:0] code,
                           input logic [20:0] a, input logic [20:0] b,
                           input logic [1:0] op, input logic go);
        exp_t e;
        e = '{code: code, a: a, b: b, op: op, go: go};
        q.push_back(e);
        n_kv_exp++;
        if (go) n_go_exp++;
        @(negedge clk);
        prow    = r;
        pmask   = m;
        pressed = 1'b1;
        repeat (48) @(negedge clk);
        pressed = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] code, input logic [20:0] a, input logic [20:0] b,
                       input logic [1:0] op, input logic go);
        logic [3:0] m;
        m = 4'b0001 << code[1:0];
        key_raw(code[3:2], m, code, a, b, op, go);
    endtask

    // Press a switch and wait until its row is being driven.
    task automatic press_until_row(input logic [1:0] r, input logic [3:0] m, input string name);
        int i;
        @(negedge clk);
        prow    = r;
        pmask   = m;
        pressed = 1'b1;
        for (i = 0; i < 64 && bus.row !== w_sel; i++) @(negedge clk);
        if (bus.row !== w_sel) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: row %b never reached %b", name, bus.row, w_sel);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row"},       32'(bus.row),       32'h0000000E);
        chk({tag, "_adata"},     32'(bus.adata),     32'(E));
        chk({tag, "_bdata"},     32'(bus.bdata),     32'(E));
        chk({tag, "_op"},        32'(bus.op),        32'd0);
        chk({tag, "_calc_go"},   32'(bus.calc_go),   32'd0);
        chk({tag, "_key_valid"}, 32'(bus.key_valid), 32'd0);
        chk({tag, "_key_code"},  32'(bus.key_code),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Three digits right-aligned, then clear.
        key(4'd1,  E, 21'h0DDDD1, 2'd0, 1'b0);
        key(4'd2,  E, 21'h0DDD12, 2'd0, 1'b0);
        key(4'd3,  E, 21'h0DD123, 2'd0, 1'b0);
        key(4'd15, E, E,          2'd0, 1'b0);

        // 45 + 6 =
        key(4'd4,  E,          21'h0DDDD4, 2'd0, 1'b0);
        key(4'd5,  E,          21'h0DDD45, 2'd0, 1'b0);
        key(4'd10, 21'h0DDD45, E,          2'd0, 1'b0);
        key(4'd6,  21'h0DDD45, 21'h0DDDD6, 2'd0, 1'b0);
        key(4'd13, 21'h0DDD45, 21'h0DDDD6, 2'd0, 1'b1);

        // Digit after '=' restarts; operator override; ignored keys in S_DONE.
        key(4'd2,  E,          21'h0DDDD2, 2'd0, 1'b0);
        key(4'd3,  E,          21'h0DDD23, 2'd0, 1'b0);
        key(4'd11, 21'h0DDD23, E,          2'd1, 1'b0);
        key(4'd12, 21'h0DDD23, E,          2'd2, 1'b0);
        key(4'd7,  21'h0DDD23, 21'h0DDDD7, 2'd2, 1'b0);
        key(4'd13, 21'h0DDD23, 21'h0DDDD7, 2'd2, 1'b1);
        key(4'd10, 21'h0DDD23, 21'h0DDDD7, 2'd2, 1'b0);
        key(4'd14, 21'h0DDD23, 21'h0DDDD7, 2'd2, 1'b0);
        key(4'd13, 21'h0DDD23, 21'h0DDDD7, 2'd2, 1'b0);
        key(4'd15, E,          E,          2'd0, 1'b0);

        // Leading zeros, sign on empty, sign set, sixth digit dropped, '=' in S_A.
        key(4'd0,  E, E,          2'd0, 1'b0);
        key(4'd0,  E, E,          2'd0, 1'b0);
        key(4'd14, E, E,          2'd0, 1'b0);
        key(4'd7,  E, 21'h0DDDD7, 2'd0, 1'b0);
        key(4'd14, E, 21'h1DDDD7, 2'd0, 1'b0);
        key(4'd8,  E, 21'h1DDD78, 2'd0, 1'b0);
        key(4'd8,  E, 21'h1DD788, 2'd0, 1'b0);
        key(4'd8,  E, 21'h1D7888, 2'd0, 1'b0);
        key(4'd8,  E, 21'h178888, 2'd0, 1'b0);
        key(4'd9,  E, 21'h178888, 2'd0, 1'b0);
        key(4'd13, E, 21'h178888, 2'd0, 1'b0);
        key(4'd15, E, E,          2'd0, 1'b0);

        // Two columns low on row 2: lowest column (1) wins, code 9.
        key_raw(2'd2, 4'b1010, 4'd9, E, 21'h0DDDD9, 2'd0, 1'b0);

        // One-tick glitch must not produce a key.
        press_until_row(2'd1, 4'b0001, "glitch_row");
        repeat (4) @(negedge clk);
        pressed = 1'b0;
        repeat (24) @(negedge clk);
        chk("glitch_no_key", 32'(n_kv), 32'(n_kv_exp));

        key(4'd10, 21'h0DDDD9, E,          2'd0, 1'b0);
        key(4'd1,  21'h0DDDD9, 21'h0DDDD1, 2'd0, 1'b0);

        // Reset in the middle of a debounce.
        press_until_row(2'd1, 4'b0010, "rst_row");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        pressed = 1'b0;
        chk_reset_vals("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_key", 32'(n_kv), 32'(n_kv_exp));
        chk("midrst_bdata",  32'(bus.bdata), 32'(E));

        chk("key_count",     32'(n_kv), 32'(n_kv_exp));
        chk("calc_go_count", 32'(n_go), 32'(n_go_exp));
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per scan tick.
REQ-002 SHALL have parameter DEB_SCANS, default 4: consecutive stable scan ticks required for press and for release.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 col  input  4  keypad columns, active-low, externally pulled up.
REQ-006 row  output  4  keypad row drive, one-cold.
REQ-007 adata  output  21  first operand: bit20 sign (1 = negative), bits19:0 five BCD digits, MS digit first.
REQ-008 bdata  output  21  current entry / second operand, same format.
REQ-009 op  output  2  operator: 0 +, 1 -, 2 *.
REQ-010 calc_go  output  1  one-cycle pulse requesting computation.
REQ-011 key_valid  output  1  one-cycle pulse per debounced key press.
REQ-012 key_code  output  4  code of the last accepted key.

Function
REQ-013 SHALL pass col through a 2-flop synchronizer before any use.
REQ-014 SHALL generate a one-clk scan tick every SCAN_DIV clk cycles from a free-running counter.
REQ-015 SHALL drive row = ~(1 << idx), idx 0..3, advancing idx (3 wraps to 0) on each tick only while the synchronized col equals 4'hF.
REQ-016 When any col is low, SHALL hold idx and count ticks with an unchanged col pattern; a pattern change restarts the count at 1.
REQ-017 At DEB_SCANS stable ticks, SHALL pulse key_valid for exactly one clk and set key_code = 4*idx + c, where c is the lowest low column index.
REQ-018 After a press, SHALL accept no further key until col = 4'hF for DEB_SCANS consecutive ticks, then resume scanning; glitches shorter than DEB_SCANS ticks produce no key.
REQ-019 Key map: 0-9 digits, 10 '+', 11 '-', 12 '*', 13 '=', 14 sign toggle, 15 clear.
REQ-020 Empty field encoding SHALL be 21'h0DDDD0: sign 0, digit value 4'hD = blank, LS digit 0.
REQ-021 Each field SHALL display its n entered digits right-aligned; the 5-n unused MS digits SHALL be 4'hD.
REQ-022 Key actions SHALL update adata, bdata, op, calc_go and state on the clk edge after the key_valid cycle (1-cycle latency).
REQ-023 FSM states: S_A (entering first operand), S_B (entering second operand), S_DONE (result requested).
REQ-024 Digit: with n = 0 and digit 0, field stays empty; with n < 5, shift into bdata and increment n; with n = 5, ignore.
REQ-025 Sign toggle: with n > 0, invert bdata[20]; with n = 0, ignore.
REQ-026 Operator in S_A: adata <= bdata, bdata <= empty, n <= 0, op <= code-10, go to S_B.
REQ-027 Operator in S_B: op <= code-10 only; adata and bdata unchanged.
REQ-028 '=' in S_B: calc_go = 1 for one clk, go to S_DONE; '=' in S_A or S_DONE: ignored.
REQ-029 In S_DONE, a digit SHALL clear adata, bdata and op, then apply that digit as in S_A and go to S_A; operator and sign keys are ignored.
REQ-030 Clear in any state: adata = bdata = empty, op = 0, n = 0, go to S_A.

Reset
REQ-031 On reset SHALL set row = 4'b1110, idx = 0, all counters 0, adata = bdata = 21'h0DDDD0, op = 0, calc_go = 0, key_valid = 0, key_code = 0, state S_A.
REQ-032 Reset asserted mid-debounce or mid-release SHALL abort detection; no key_valid until a fresh full debounce.

Verification (SCAN_DIV=4, DEB_SCANS=2)
REQ-033 Press keys 1,2,3 (release each): bdata = 21'h0DD123; adata = 21'h0DDDD0.
REQ-034 Sequence 4,5,'+',6,'=': adata = 21'h0DDD45, bdata = 21'h0DDDD6, op = 0; calc_go pulses once, one clk after the '=' key_valid.
REQ-035 Keys 0,0,7, sign, 8,8,8,8,9: bdata = 21'h178888 (leading zeros absorbed, sign set, 6th digit ignored).
REQ-036 Col low for only 1 tick: no key_valid; key held 10 ticks: exactly one key_valid.
REQ-037 Two columns low at row 2 (c = 1 and 3): key_code = 9.
REQ-038 After '=', press 2: adata = 21'h0DDDD0, bdata = 21'h0DDDD2, state S_A. Separately, assert rst_n mid-debounce: all outputs return to REQ-031 values.
